module_suma_ctrl: RTL
=====================

// Module: module_suma_ctrl
// PURPOSE
//  Sequencer for the three-operand adder (a+b+c). Collects three operands one at a time from a single
//  valid/ready stream and accumulates them with one internal W+2-bit adder. It then presents the sum on
//  a valid/ready output port. It sits between an operand source and a sum consumer.
//  A new operand set is processed only after the previous sum has been taken.
// PARAMETERS
//  W      3  operand width in bits (W >= 1)
//  CNT_W  8  width of the completed-sum counter
// PORTS
//  clk            in   1      single system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  clr_i          in   1      synchronous abort: discard partial set, return to S_A
//  op_i           in   W      operand data
//  op_valid_i     in   1      op_i valid
//  op_ready_o     out  1      block can accept an operand
//  suma_o         out  W+2    a+b+c, zero-extended
//  suma_valid_o   out  1      suma_o valid
//  suma_ready_i   in   1      consumer accepts suma_o
//  busy_o         out  1      at least one operand of the current set accepted, or a sum pending
//  cnt_o          out  CNT_W  number of sums delivered (handshakes completed), wraps
//  sat_o          out  1      only with SUMA_SAT_EN: sum was clamped
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=S_A, acc=0, suma_o=0, suma_valid_o=0, busy_o=0, cnt_o=0, sat_o=0.
//    op_ready_o=1 after reset is released.
//  - Operand accept = op_valid_i & op_ready_o on a rising clk edge. Sum accept = suma_valid_o & suma_ready_i.
//  - FSM states: S_A, S_B, S_C, S_OUT. op_ready_o = 1 in S_A/S_B/S_C and 0 in S_OUT (registered state decode).
//    S_A: on accept, acc <= zext(op_i), go to S_B.
//    S_B: on accept, acc <= acc + op_i, go to S_C.
//    S_C: on accept, suma_o <= acc + op_i, suma_valid_o <= 1, go to S_OUT.
//    S_OUT: hold suma_o and suma_valid_o stable. On sum accept, suma_valid_o <= 0, cnt_o <= cnt_o+1, go to S_A.
//  - Without op_valid_i the FSM holds its state. Gaps between operands are allowed.
//  - Latency: suma_valid_o rises 1 cycle after the third operand is accepted.
//    Minimum period is 4 cycles per sum: no S_OUT->S_A bypass, so there is no same-cycle accept of a new operand.
//  - Arithmetic: unsigned, W+2 bits, no overflow possible (max 3*(2^W-1) < 2^(W+2)).
//  - busy_o = (state != S_A).
//  - clr_i (sync, priority over all handshakes in the same cycle):
//    state <= S_A, acc <= 0, suma_valid_o <= 0. A pending sum is dropped and cnt_o is not incremented.
//    cnt_o is not cleared.
//  - cnt_o wraps from 2^CNT_W-1 to 0.
//  - Reset asserted mid-set: the partial set is lost immediately and all outputs take their reset values.
// CONFIGURATION
//  SUMA_SAT_EN defined:
//    - In S_C, if acc+op_i > 2^W-1, suma_o <= 2^W-1 (zero-extended) and sat_o <= 1; else sat_o <= 0.
//    - sat_o is valid with suma_valid_o and is cleared by reset and by clr_i.
//  SUMA_SAT_EN undefined:
//    - The sat_o port and the clamp logic are absent. suma_o is the full W+2-bit sum.
// TESTING
//  1) rst_n=0 then 1; check op_ready_o=1, suma_valid_o=0, cnt_o=0, busy_o=0.
//  2) W=3, ops 6,4,5 on consecutive cycles, suma_ready_i=1 -> suma_o=5'd15 one cycle after op 5;
//     cnt_o=1 after the sum handshake.
//  3) ops 7,7,7 -> suma_o=5'd21 (no SAT_EN). With SUMA_SAT_EN -> suma_o=5'd7, sat_o=1.
//     ops 1,2,3 -> suma_o=6, sat_o=0.
//  4) ops 1,2,3 with suma_ready_i=0 for 5 cycles -> suma_o=6 held stable, op_ready_o=0 throughout;
//     the 4th op_valid_i is ignored until suma_ready_i=1.
//  5) ops 3,3 then clr_i=1 together with op_valid_i=1 (op=3) -> set discarded, state S_A, busy_o=0.
//     Then ops 1,1,1 -> suma_o=3.
//  6) rst_n=0 pulsed mid-operation in S_B and in S_OUT -> immediate reset values.
//     256 back-to-back sums -> cnt_o wraps to 0.

Source files
------------

// File: rtl/module_suma_ctrl_if.sv
// Operand/sum valid-ready bundle for module_suma_ctrl.
// The slave modport faces the sequencer; the master modport faces the source/consumer side.
interface module_suma_ctrl_if #(
    parameter int W = 3
);
    logic [W-1:0] op_i;
    logic         op_valid_i;
    logic         op_ready_o;
    logic [W+1:0] suma_o;
    logic         suma_valid_o;
    logic         suma_ready_i;

    modport slave (
        input  op_i,
        input  op_valid_i,
        output op_ready_o,
        output suma_o,
        output suma_valid_o,
        input  suma_ready_i
    );

    modport master (
        output op_i,
        output op_valid_i,
        input  op_ready_o,
        input  suma_o,
        input  suma_valid_o,
        output suma_ready_i
    );
endinterface

// File: rtl/module_suma_ctrl.sv
// Three-operand (a+b+c) sequencer: takes operands one per handshake, accumulates them, offers the sum.
// Optional SUMA_SAT_EN clamps the sum to 2^W-1 and reports the clamp on sat_o.
module module_suma_ctrl #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    module_suma_ctrl_if.slave sif,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cnt_o
`ifdef SUMA_SAT_EN
    ,
    output logic              sat_o
`endif
);
    localparam int SW = W + 2;

    localparam logic [1:0] S_A   = 2'd0;
    localparam logic [1:0] S_B   = 2'd1;
    localparam logic [1:0] S_C   = 2'd2;
    localparam logic [1:0] S_OUT = 2'd3;

    logic [1:0]       state;
    logic [SW-1:0]    acc;
    logic [SW-1:0]    suma_q;
    logic             suma_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW-1:0]    op_ext;
    logic [SW-1:0]    sum_c;
    logic             op_acc;
    logic             suma_acc;

`ifdef SUMA_SAT_EN
    logic sat_q;

    function automatic logic [SW-1:0] sat_clamp(input logic [SW-1:0] s);
        logic [SW-1:0] lim;
        lim = {2'b00, {W{1'b1}}};
        return (s > lim) ? lim : s;
    endfunction

    function automatic logic sat_flag(input logic [SW-1:0] s);
        return s > {2'b00, {W{1'b1}}};
    endfunction
`endif

    assign op_ext   = {2'b00, sif.op_i};
    assign sum_c    = acc + op_ext;
    assign op_acc   = sif.op_valid_i & sif.op_ready_o;
    assign suma_acc = suma_valid_q & sif.suma_ready_i;

    // Ready and busy are pure decodes of the registered state.
    assign sif.op_ready_o   = (state != S_OUT);
    assign sif.suma_o       = suma_q;
    assign sif.suma_valid_o = suma_valid_q;
    assign busy_o           = (state != S_A);
    assign cnt_o            = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_A;
            acc          <= '0;
            suma_q       <= '0;
            suma_valid_q <= 1'b0;
            cnt_q        <= '0;
`ifdef SUMA_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else if (clr_i) begin
            // Abort wins over any handshake this cycle; the delivered-sum count survives.
            state        <= S_A;
            acc          <= '0;
            suma_valid_q <= 1'b0;
`ifdef SUMA_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_A: begin
                    if (op_acc) begin
                        acc   <= op_ext;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (op_acc) begin
                        acc   <= sum_c;
                        state <= S_C;
                    end
                end
                S_C: begin
                    if (op_acc) begin
`ifdef SUMA_SAT_EN
                        suma_q <= sat_clamp(sum_c);
                        sat_q  <= sat_flag(sum_c);
`else
                        suma_q <= sum_c;
`endif
                        suma_valid_q <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                default: begin
                    // No bypass to accepting a new operand in the same cycle as the sum leaves.
                    if (suma_acc) begin
                        suma_valid_q <= 1'b0;
                        cnt_q        <= cnt_q + 1'b1;
                        state        <= S_A;
                    end
                end
            endcase
        end
    end

`ifdef SUMA_SAT_EN
    assign sat_o = sat_q;
`endif
endmodule
